// File: rtl/risa_pkg.sv
// Shared types and constants for the RISA command sequencer.
// Opcode/payload widths, response status codes and FSM states.
package risa_pkg;

  localparam int OP_W   = 4;
  localparam int DATA_W = 64;
  localparam int CMD_W  = OP_W + DATA_W;

  localparam logic [OP_W-1:0] OP_MAX_VALID = 4'hB;

  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_TIMEOUT = 2'b01,
    STAT_BAD_OP  = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCK,
    S_ISSUE,
    S_WAIT_ACK,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } cmd_t;

  function automatic logic op_valid(input logic [OP_W-1:0] op);
    return op <= OP_MAX_VALID;
  endfunction

endpackage

// File: rtl/risa_cmd_fifo.sv
// Host command buffer: power-of-two FIFO with wrap-bit pointers.
// Head entry is visible combinationally on rdata_o.
module risa_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 68
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full buffer is allowed when the head leaves that cycle.
  always_comb begin
    do_push  = push_i && (!full_o || pop_i);
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since pointers gate reads.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/risa_cmd_sequencer.sv
// Host-to-core command sequencer: buffers host commands, locks core
// state, issues one command, waits for ack or timeout, responds.
module risa_cmd_sequencer
  import risa_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic [OP_W-1:0]   host_op_i,
  input  logic [DATA_W-1:0] host_data_i,
  output logic              core_cmd_valid_o,
  output logic [OP_W-1:0]   core_cmd_op_o,
  output logic [DATA_W-1:0] core_cmd_data_o,
  output logic              state_lock_cmd_o,
  input  logic              core_busy_i,
  input  logic              core_ack_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [1:0]        resp_status_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 2);

  state_e              state_q, state_d;
  status_e             status_q, status_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                fifo_full, fifo_empty;
  logic                fifo_push, fifo_pop;
  logic [CMD_W-1:0]    fifo_rdata;
  cmd_t                head;

  assign host_ready_o = !fifo_full;
  assign fifo_push    = host_valid_i && host_ready_o;
  assign head         = cmd_t'(fifo_rdata);

  risa_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i ({host_op_i, host_data_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state, counter, captured command and decoded outputs.
  always_comb begin
    state_d          = state_q;
    status_d         = status_q;
    cnt_d            = cnt_q;
    op_d             = op_q;
    data_d           = data_q;
    fifo_pop         = 1'b0;
    state_lock_cmd_o = 1'b0;
    core_cmd_valid_o = 1'b0;
    resp_valid_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (op_valid(head.op)) begin
            state_d = S_LOCK;
          end else begin
            fifo_pop = 1'b1;
            status_d = STAT_BAD_OP;
            state_d  = S_RESP;
          end
        end
      end
      S_LOCK: begin
        state_lock_cmd_o = 1'b1;
        if (!core_busy_i) begin
          op_d    = head.op;
          data_d  = head.data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_lock_cmd_o = 1'b1;
        core_cmd_valid_o = 1'b1;
        fifo_pop         = 1'b1;
        cnt_d            = '0;
        state_d          = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        state_lock_cmd_o = 1'b1;
        if (core_ack_i) begin
          status_d = STAT_OK;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          status_d = STAT_TIMEOUT;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign core_cmd_op_o   = op_q;
  assign core_cmd_data_o = data_q;
  assign resp_status_o   = status_q;

  // State, timeout counter, status and issued-command registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      status_q <= STAT_OK;
      cnt_q    <= '0;
      op_q     <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_risa_cmd_sequencer.sv
// Self-checking bench for risa_cmd_sequencer (depth 4, timeout 16).
// Directed steps with a command/response scoreboard.
module tb_risa_cmd_sequencer;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TO  = 2'b01;
  localparam logic [1:0] ST_BAD = 2'b10;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        host_valid_i = 1'b0;
  logic        host_ready_o;
  logic [3:0]  host_op_i = '0;
  logic [63:0] host_data_i = '0;
  logic        core_cmd_valid_o;
  logic [3:0]  core_cmd_op_o;
  logic [63:0] core_cmd_data_o;
  logic        state_lock_cmd_o;
  logic        core_busy_i = 1'b0;
  logic        core_ack_i;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic [1:0]  resp_status_o;

  logic        ack_auto = 1'b0;
  logic        ack_stray = 1'b0;
  logic        ack_en = 1'b0;
  int          ack_delay = 1;

  assign core_ack_i = ack_auto | ack_stray;

  int tests = 0;
  int fails = 0;
  int lock_cnt = 0;
  int strobe_cnt = 0;

  logic [67:0] cmd_q [$];
  logic [1:0]  resp_q [$];

  risa_cmd_sequencer #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .host_valid_i     (host_valid_i),
    .host_ready_o     (host_ready_o),
    .host_op_i        (host_op_i),
    .host_data_i      (host_data_i),
    .core_cmd_valid_o (core_cmd_valid_o),
    .core_cmd_op_o    (core_cmd_op_o),
    .core_cmd_data_o  (core_cmd_data_o),
    .state_lock_cmd_o (state_lock_cmd_o),
    .core_busy_i      (core_busy_i),
    .core_ack_i       (core_ack_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_status_o    (resp_status_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops and activity counters.
  initial forever begin
    @(negedge clk_i);
    if (!rst_i) begin
      if (state_lock_cmd_o) lock_cnt++;
      if (core_cmd_valid_o) begin
        strobe_cnt++;
        chk("strobe_expected", cmd_q.size() > 0, 1);
        if (cmd_q.size() > 0)
          chk("cmd", {core_cmd_op_o, core_cmd_data_o}, cmd_q.pop_front());
      end
      if (resp_valid_o && resp_ready_i) begin
        chk("resp_expected", resp_q.size() > 0, 1);
        if (resp_q.size() > 0)
          chk("resp_status", resp_status_o, resp_q.pop_front());
      end
    end
  end

  // Core model: ack a fixed number of cycles after each strobe.
  initial forever begin
    @(negedge clk_i);
    if (core_cmd_valid_o && ack_en && !rst_i) begin
      for (int i = 0; i < ack_delay; i++) @(posedge clk_i);
      #1 ack_auto = 1'b1;
      @(posedge clk_i);
      #1 ack_auto = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [63:0] d);
    bit done = 0;
    host_valid_i = 1'b1;
    host_op_i    = op;
    host_data_i  = d;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk_i);
      if (host_ready_o) done = 1;
      @(posedge clk_i);
      #1;
    end
    host_valid_i = 1'b0;
    if (done && op <= 4'hB) cmd_q.push_back({op, d});
    chk("push_accepted", done, 1);
  endtask

  task automatic wait_strobe(output int n);
    bit seen = 0;
    n = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_i);
      n++;
      if (core_cmd_valid_o) seen = 1;
    end
    chk("strobe_seen", seen, 1);
  endtask

  task automatic wait_rv(output int n);
    bit seen = 0;
    n = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_i);
      n++;
      if (resp_valid_o) seen = 1;
    end
    chk("resp_seen", seen, 1);
  endtask

  initial begin
    int n;
    // Reset values, while asserted and after release.
    #1;
    chk("rst_lock", state_lock_cmd_o, 0);
    chk("rst_cmd_valid", core_cmd_valid_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    tick();
    chk("rel_ready", host_ready_o, 1);
    chk("rel_op", core_cmd_op_o, 0);
    chk("rel_data", core_cmd_data_o, 0);
    chk("rel_status", resp_status_o, 0);
    chk("rel_lock", state_lock_cmd_o, 0);

    // Basic command, ack two cycles after strobe.
    ack_en = 1'b1;
    ack_delay = 2;
    lock_cnt = 0;
    push(4'h1, 64'hDEAD_BEEF);
    resp_q.push_back(ST_OK);
    wait_strobe(n);
    chk("latency", n, 3);
    wait_rv(n);
    chk("ack_to_resp", n, 3);
    tick();
    chk("lock_cycles", lock_cnt, 4);
    chk("hold_op", core_cmd_op_o, 4'h1);
    chk("hold_data", core_cmd_data_o, 64'hDEAD_BEEF);

    // Invalid opcode: no lock, no strobe.
    lock_cnt = 0;
    strobe_cnt = 0;
    push(4'hD, 64'h5);
    resp_q.push_back(ST_BAD);
    wait_rv(n);
    tick();
    chk("bad_lock", lock_cnt, 0);
    chk("bad_strobe", strobe_cnt, 0);

    // Timeout with response backpressure.
    ack_en = 1'b0;
    resp_ready_i = 1'b0;
    lock_cnt = 0;
    push(4'h2, 64'h1234_5678_9ABC_DEF0);
    resp_q.push_back(ST_TO);
    wait_strobe(n);
    wait_rv(n);
    chk("timeout_cycles", n, 16);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("bp_valid", resp_valid_o, 1);
      chk("bp_status", resp_status_o, ST_TO);
    end
    tick();
    resp_ready_i = 1'b1;
    tick();
    chk("to_unlock", state_lock_cmd_o, 0);
    chk("to_lock_cycles", lock_cnt, 17);

    // Busy core holds LOCK; then a stray ack in IDLE.
    ack_en = 1'b1;
    ack_delay = 1;
    core_busy_i = 1'b1;
    strobe_cnt = 0;
    push(4'h3, 64'hCAFE);
    resp_q.push_back(ST_OK);
    repeat (20) tick();
    chk("busy_no_strobe", strobe_cnt, 0);
    chk("busy_lock", state_lock_cmd_o, 1);
    core_busy_i = 1'b0;
    wait_strobe(n);
    chk("busy_release", n, 2);
    wait_rv(n);
    tick();
    ack_stray = 1'b1;
    tick();
    ack_stray = 1'b0;
    repeat (2) tick();
    chk("stray_no_resp", resp_valid_o, 0);
    ack_en = 1'b0;
    push(4'h9, 64'h99);
    resp_q.push_back(ST_TO);
    wait_rv(n);
    tick();

    // Fill buffer while busy, then stream ten commands across wrap.
    ack_en = 1'b1;
    ack_delay = 1;
    core_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(4'(4 + i), 64'h1000 + 64'(i));
      resp_q.push_back(ST_OK);
    end
    @(negedge clk_i);
    chk("full_ready", host_ready_o, 0);
    tick();
    core_busy_i = 1'b0;
    for (int i = 4; i < 10; i++) begin
      push(4'(i), 64'h1000 + 64'(i));
      resp_q.push_back(ST_OK);
    end
    for (int k = 0; k < 500 && resp_q.size() != 0; k++) tick();
    chk("stream_drained", resp_q.size(), 0);

    // Reset in WAIT_ACK with a queued command.
    ack_en = 1'b0;
    push(4'h8, 64'hABCD);
    wait_strobe(n);
    tick();
    push(4'hA, 64'h77);
    chk("pre_rst_lock", state_lock_cmd_o, 1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_lock", state_lock_cmd_o, 0);
    chk("mid_rst_valid", core_cmd_valid_o, 0);
    chk("mid_rst_op", core_cmd_op_o, 0);
    chk("mid_rst_data", core_cmd_data_o, 0);
    chk("mid_rst_resp", resp_valid_o, 0);
    chk("mid_rst_status", resp_status_o, 0);
    chk("mid_rst_ready", host_ready_o, 1);
    cmd_q.delete();
    resp_q.delete();
    tick();
    rst_i = 1'b0;
    strobe_cnt = 0;
    lock_cnt = 0;
    repeat (8) tick();
    chk("post_rst_strobe", strobe_cnt, 0);
    chk("post_rst_lock", lock_cnt, 0);
    chk("post_rst_resp", resp_valid_o, 0);

    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
